// File: rtl/roic_frame_sequencer.sv
// Frame sequencer for the ROIC readout: pixel reset, integration, then a
// settle/scan pass over every row, then a one-cycle completion state.
// Every output is decoded from registered state and counters only.
module roic_frame_sequencer #(
  parameter int unsigned ROWS       = 512,
  parameter int unsigned COLS       = 640,
  parameter int unsigned ROW_W      = 9,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned RST_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned INT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic             abort_i,
  input  logic [INT_W-1:0] int_time_i,
  output logic             busy_o,
  output logic             pix_rst_o,
  output logic             integ_o,
  output logic [ROW_W-1:0] row_addr_o,
  output logic [COL_W-1:0] col_addr_o,
  output logic             pix_valid_o,
  output logic             sof_o,
  output logic             eol_o,
  output logic             frame_done_o,
  output logic [15:0]      frame_cnt_o
);

  typedef enum logic [2:0] {
    StIdle,
    StPrst,
    StInteg,
    StSettle,
    StScan,
    StDone
  } state_e;

  // Terminal values of the phase counter and the raster counters.
  localparam logic [INT_W-1:0] RstTerm    = INT_W'(RST_CYC - 1);
  localparam logic [INT_W-1:0] SettleTerm = INT_W'(SETTLE_CYC - 1);
  localparam logic [ROW_W-1:0] RowLast    = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] ColLast    = COL_W'(COLS - 1);
  localparam logic [INT_W-1:0] IntOne     = INT_W'(1);

  state_e           state_q, state_d;
  logic [INT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [INT_W-1:0] t_lat_q, t_lat_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      phase_cnt_q <= '0;
      t_lat_q     <= IntOne;
      row_q       <= '0;
      col_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      t_lat_q     <= t_lat_d;
      row_q       <= row_d;
      col_q       <= col_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state logic; abort outranks every phase transition outside idle.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    t_lat_d     = t_lat_q;
    row_d       = row_q;
    col_d       = col_q;
    frame_cnt_d = frame_cnt_q;

    if (abort_i && (state_q != StIdle)) begin
      state_d     = StIdle;
      phase_cnt_d = '0;
      row_d       = '0;
      col_d       = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          row_d = '0;
          col_d = '0;
          if (start_i) begin
            // A zero integration time would never terminate; run one cycle instead.
            t_lat_d     = (int_time_i == '0) ? IntOne : int_time_i;
            phase_cnt_d = '0;
            state_d     = StPrst;
          end
        end
        StPrst: begin
          if (phase_cnt_q == RstTerm) begin
            phase_cnt_d = '0;
            state_d     = StInteg;
          end else begin
            phase_cnt_d = phase_cnt_q + IntOne;
          end
        end
        StInteg: begin
          if (phase_cnt_q == (t_lat_q - IntOne)) begin
            phase_cnt_d = '0;
            row_d       = '0;
            state_d     = StSettle;
          end else begin
            phase_cnt_d = phase_cnt_q + IntOne;
          end
        end
        StSettle: begin
          if (phase_cnt_q == SettleTerm) begin
            phase_cnt_d = '0;
            col_d       = '0;
            state_d     = StScan;
          end else begin
            phase_cnt_d = phase_cnt_q + IntOne;
          end
        end
        StScan: begin
          if (col_q == ColLast) begin
            col_d = '0;
            if (row_q == RowLast) begin
              row_d   = '0;
              state_d = StDone;
            end else begin
              row_d   = row_q + ROW_W'(1);
              state_d = StSettle;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
        StDone: begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          phase_cnt_d = '0;
          state_d     = cont_i ? StPrst : StIdle;
        end
        default: begin
          state_d     = StIdle;
          phase_cnt_d = '0;
          row_d       = '0;
          col_d       = '0;
        end
      endcase
    end
  end

  // Output decode from registered state and raster counters.
  always_comb begin
    busy_o       = (state_q != StIdle);
    pix_rst_o    = (state_q == StPrst);
    integ_o      = (state_q == StInteg);
    pix_valid_o  = (state_q == StScan);
    sof_o        = (state_q == StScan) && (row_q == '0) && (col_q == '0);
    eol_o        = (state_q == StScan) && (col_q == ColLast);
    frame_done_o = (state_q == StDone);
  end

  assign row_addr_o  = row_q;
  assign col_addr_o  = col_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: doc/roic_frame_sequencer.md
# roic_frame_sequencer

Frame-level controller for the 640x512 ROIC readout. It sequences each frame through four phases: pixel reset, integration, a row-settle/column-scan loop over every row, and frame completion. It drives the row and column addresses, the pixel data-valid and the framing strobes that the row/column enable logic and the downstream sampling path consume. It supports single-shot and continuous capture, a latched programmable integration time, and abort.

## Interface
- ROWS, 512, rows per frame
- COLS, 640, columns per row
- ROW_W, 9, row address width
- COL_W, 10, column address width
- RST_CYC, 4, pixel-reset phase length in cycles (≥1)
- SETTLE_CYC, 2, row-select settle cycles before each row scan (≥1)
- INT_W, 16, integration-time field width

- clk  input  1  single system clock, rising edge
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk)
- start  input  1  begin capture; sampled only in IDLE
- cont  input  1  continuous mode; sampled in DONE
- abort  input  1  terminate frame; highest priority after reset
- int_time  input  INT_W  integration cycles; latched on accepted start
- busy  output  1  high in every state except IDLE
- pix_rst  output  1  pixel reset, high in PRST
- integ  output  1  integration window, high in INTEG
- row_addr  output  ROW_W  current row
- col_addr  output  COL_W  current column
- pix_valid  output  1  high in SCAN, one pixel per cycle
- sof  output  1  high with pixel (0,0) only
- eol  output  1  high with column COLS-1 of every row
- frame_done  output  1  one-cycle pulse in DONE
- frame_cnt  output  16  completed frames, wraps at 0xFFFF→0

## Operation
- States: IDLE, PRST, INTEG, SETTLE, SCAN, DONE. All outputs are decoded from registered state and counters, with no combinational input-to-output paths.
- IDLE:
  - start=1 latches int_time into t_lat (0 is treated as 1) and moves to PRST.
  - row_addr=col_addr=0.
- PRST: lasts RST_CYC cycles, then INTEG.
- INTEG: lasts t_lat cycles, then SETTLE with row_addr=0.
- SETTLE:
  - Lasts SETTLE_CYC cycles, then SCAN with col_addr=0.
  - pix_valid=0; row_addr holds.
- SCAN:
  - Lasts COLS cycles; col_addr increments 0..COLS-1.
  - After column COLS-1: if row_addr<ROWS-1, row_addr increments and the FSM enters SETTLE. Otherwise it enters DONE.
- DONE:
  - Lasts one cycle; frame_done=1 and frame_cnt increments.
  - Next state is PRST if cont=1, else IDLE. t_lat is retained across continuous frames.
- start is ignored while busy=1.
- abort=1 in any non-IDLE state moves to IDLE on the next edge:
  - all strobes are cleared and addresses return to 0;
  - no frame_done pulse and no frame_cnt increment;
  - if abort and start are both high in IDLE, start wins (abort has no effect in IDLE).
- Arithmetic: the phase counter is INT_W wide and compares against the terminal value. The row/column counters never exceed ROWS-1/COLS-1.

## Timing
- Reset (rst=0 at an edge):
  - next cycle: state IDLE;
  - busy, pix_rst, integ, pix_valid, sof, eol and frame_done are 0;
  - row_addr=0, col_addr=0, frame_cnt=0.
  - This holds mid-frame too; reset overrides abort and start.
- start sampled high at edge k: busy=pix_rst=1 from cycle k+1.
- Frame length from the first PRST cycle to the DONE cycle inclusive = RST_CYC + t_lat + ROWS·(SETTLE_CYC+COLS) + 1. With defaults and t_lat=100 this is 328,809 cycles.
- Continuous mode: PRST of frame n+1 immediately follows DONE of frame n, with no idle gap.
- sof and eol coincide in the same cycle only when COLS=1.

## Test plan
Use ROWS=4, COLS=5, RST_CYC=2, SETTLE_CYC=1 unless noted.
- Reset: hold rst=0 for 3 cycles while start=1 -> all outputs at reset values, busy stays 0; release -> FSM enters PRST one cycle after start is first sampled.
- Single frame, int_time=3, cont=0 -> pix_rst high 2 cycles, integ high 3, 20 pix_valid cycles in raster order, 4 eol, 1 sof, frame_done at cycle 30, frame_cnt=1, then IDLE.
- int_time=0 -> integ high exactly 1 cycle; frame length 28.
- Continuous mode, 3 frames -> frame_done pulses exactly 30 cycles apart, pix_rst the cycle after each DONE, frame_cnt=3. Change int_time mid-run -> period unchanged.
- Abort asserted on the 2nd SCAN cycle of row 2 -> IDLE next cycle, pix_valid=0, addresses 0, frame_cnt unchanged, no frame_done. A new start then yields a full 30-cycle frame.
- frame_cnt preloaded via force to 0xFFFF, one frame -> wraps to 0. start pulsed during SCAN -> ignored, frame timing unchanged.
